// File: rtl/ram_pkg.sv
// ram_pkg: shared size codes, FSM states and access legality check for ram_v2.
package ram_pkg;

    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } ram_state_e;

    // Unsigned sizes exist only for loads; halves and words must be naturally aligned.
    function automatic logic is_legal(input logic [2:0] size, input logic wr, input logic [1:0] addr_lsbs);
        return (size == SZ_B)
            || (size == SZ_H && !addr_lsbs[0])
            || (size == SZ_W && addr_lsbs == 2'b00)
            || (!wr && size == SZ_BU)
            || (!wr && size == SZ_HU && !addr_lsbs[0]);
    endfunction

endpackage

// File: rtl/ram_v2_lane_align.sv
// ram_v2_lane_align: store-side byte strobe/data placement and load-side
// lane extraction with sign or zero extension.
module ram_v2_lane_align
    import ram_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]          st_funct3,
    input  logic [1:0]          st_lane,
    input  logic [DATA_W-1:0]   st_wdata,
    output logic [DATA_W/8-1:0] st_strb,
    output logic [DATA_W-1:0]   st_wdata_sh,
    input  logic [2:0]          ld_funct3,
    input  logic [1:0]          ld_lane,
    input  logic [DATA_W-1:0]   ld_word,
    output logic [DATA_W-1:0]   ld_data
);
    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    always_comb begin
        st_strb     = st_funct3 == SZ_B ? (DATA_W/8)'(1) << st_lane
                    : st_funct3 == SZ_H ? (DATA_W/8)'(3) << {st_lane[1], 1'b0}
                    : '1;
        // Bytes outside the strobe are don't-care, so one shift serves every size.
        st_wdata_sh = st_wdata << {st_lane, 3'b000};
        ld_b        = ld_word[{ld_lane, 3'b000} +: 8];
        ld_h        = ld_word[{ld_lane[1], 4'b0000} +: 16];
        ld_data     = ld_funct3 == SZ_B  ? {{(DATA_W-8){ld_b[7]}}, ld_b}
                    : ld_funct3 == SZ_H  ? {{(DATA_W-16){ld_h[15]}}, ld_h}
                    : ld_funct3 == SZ_BU ? {{(DATA_W-8){1'b0}}, ld_b}
                    : ld_funct3 == SZ_HU ? {{(DATA_W-16){1'b0}}, ld_h}
                    : ld_word;
    end

endmodule

// File: rtl/ram_v2.sv
// ram_v2: byte-addressable data RAM with RV32 load/store sizes, error reporting,
// configurable read latency and a single-outstanding valid/ready handshake.
module ram_v2
    import ram_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 12,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);
    localparam int DEPTH = 2 ** (ADDR_W - 2);
    localparam int NB    = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rword_q;
    ram_state_e        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        lane_q, lane_d;
    logic              wr_q, wr_d;
    logic              err_q, err_d;
    logic              accept, legal;
    logic [NB-1:0]     strb;
    logic [DATA_W-1:0] wdata_sh, ld_data;

    assign req_ready = rst && state_q == IDLE;
    assign accept    = req_valid && req_ready;
    assign legal     = is_legal(req_funct3, req_wr, req_addr[1:0]);
    assign rsp_valid = state_q == RESP;
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && !err_q && !wr_q) ? ld_data : '0;

    ram_v2_lane_align #(.DATA_W(DATA_W)) u_align (
        .st_funct3   (req_funct3),
        .st_lane     (req_addr[1:0]),
        .st_wdata    (req_wdata),
        .st_strb     (strb),
        .st_wdata_sh (wdata_sh),
        .ld_funct3   (funct3_q),
        .ld_lane     (lane_q),
        .ld_word     (rword_q),
        .ld_data     (ld_data)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        funct3_d = funct3_q;
        lane_d   = lane_q;
        wr_d     = wr_q;
        err_d    = err_q;
        if (accept) begin
            state_d  = (legal && !req_wr && READ_LAT > 1) ? WAIT : RESP;
            cnt_d    = 3'd1;
            funct3_d = req_funct3;
            lane_d   = req_addr[1:0];
            wr_d     = req_wr;
            err_d    = !legal;
        end else if (state_q == WAIT) begin
            state_d = cnt_q == 3'(READ_LAT - 1) ? RESP : WAIT;
            cnt_d   = cnt_q + 3'd1;
        end else if (state_q == RESP && rsp_ready) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            funct3_q <= '0;
            lane_q   <= '0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            funct3_q <= funct3_d;
            lane_q   <= lane_d;
            wr_q     <= wr_d;
            err_q    <= err_d;
        end
    end

    // Storage is deliberately outside reset so committed data survives it.
    always_ff @(posedge clk) begin
        if (accept && !req_wr)
            rword_q <= mem[req_addr[ADDR_W-1:2]];
        for (int b = 0; b < NB; b++)
            if (accept && req_wr && legal && strb[b])
                mem[req_addr[ADDR_W-1:2]][b*8 +: 8] <= wdata_sh[b*8 +: 8];
    end

endmodule

// File: tb/tb_ram_v2.sv
// tb_ram_v2: byte-array reference model with a per-cycle compare process,
// directed literal checks and randomized traffic with response backpressure.
module tb_ram_v2;
    localparam int L = 3;

    logic        clk = 0, rst = 1, req_valid = 0, req_wr = 0, rsp_ready = 1;
    logic [2:0]  req_funct3 = 0;
    logic [11:0] req_addr = 0;
    logic [31:0] req_wdata = 0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    int          ncmp = 0, nerr = 0, cyc = 0, acc_e = 0, exp_l = 1;
    bit          pend = 0, exp_e = 0, bp_en = 0;
    logic [31:0] exp_d = 0;
    logic [7:0]  mdl [4096];

    always #5 clk = ~clk;

    ram_v2 #(.DATA_W(32), .ADDR_W(12), .READ_LAT(L)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_wr(req_wr), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    function automatic bit legal_f(bit wr, logic [2:0] f3, logic [11:0] a);
        case (f3)
            3'd0: return 1;
            3'd1: return !a[0];
            3'd2: return a[1:0] == 2'b00;
            3'd4: return !wr;
            3'd5: return !wr && !a[0];
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] load_f(logic [2:0] f3, logic [11:0] a);
        logic [31:0] w;
        w = {mdl[(int'(a) + 3) % 4096], mdl[(int'(a) + 2) % 4096], mdl[(int'(a) + 1) % 4096], mdl[a]};
        case (f3)
            3'd0: return 32'($signed(w[7:0]));
            3'd1: return 32'($signed(w[15:0]));
            3'd4: return {24'd0, w[7:0]};
            3'd5: return {16'd0, w[15:0]};
            default: return w;
        endcase
    endfunction

    function void chk(string nm, logic [31:0] act, logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Reference model: updated on each rising edge from the request/response handshakes.
    always @(posedge clk) begin
        bit lg;
        int n;
        if (!rst) pend = 0;
        else if (pend) begin
            if (cyc >= acc_e + exp_l && rsp_ready) pend = 0;
        end else if (req_valid) begin
            lg    = legal_f(req_wr, req_funct3, req_addr);
            exp_e = !lg;
            exp_l = (lg && !req_wr) ? L : 1;
            exp_d = (lg && !req_wr) ? load_f(req_funct3, req_addr) : 32'd0;
            if (lg && req_wr) begin
                n = req_funct3 == 3'd0 ? 1 : req_funct3 == 3'd1 ? 2 : 4;
                for (int i = 0; i < n; i++) mdl[(int'(req_addr) + i) % 4096] = req_wdata[8*i +: 8];
            end
            pend  = 1;
            acc_e = cyc;
        end
        cyc++;
    end

    always @(negedge clk) begin
        bit ev;
        ev = rst && pend && cyc >= acc_e + exp_l;
        chk("req_ready", 32'(req_ready), 32'(rst && !pend));
        chk("rsp_valid", 32'(rsp_valid), 32'(ev));
        if (ev || !rst) begin
            chk("rsp_rdata", rsp_rdata, ev ? exp_d : 32'd0);
            chk("rsp_err", 32'(rsp_err), 32'(ev && exp_e));
        end
    end

    always @(posedge clk) if (bp_en) begin
        #1 rsp_ready = $urandom_range(0, 3) != 0;
    end

    task automatic tmo(string nm);
        ncmp++;
        nerr++;
        $display("FAIL timeout %s (t=%0t)", nm, $time);
    endtask

    task automatic xact(input bit wr, input logic [2:0] f3, input logic [11:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
        int n;
        req_valid = 1; req_wr = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready && n < 50);
        if (!req_ready) tmo("req_ready");
        @(posedge clk); #1 req_valid = 0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 50);
        if (!rsp_valid) tmo("rsp_valid");
        rd = rsp_rdata; er = rsp_err;
        n = 0;
        while (!(rsp_valid && rsp_ready) && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) tmo("rsp_consume");
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, wd;
        logic        er, wr;
        int          lat, n;
        logic [2:0]  f3;
        logic [11:0] a;
        logic [2:0]  tbl [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        #2 rst = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1;
        for (int w = 0; w < 64; w++) xact(1, 3'd2, 12'(w * 4), $urandom, rd, er, lat);

        xact(1, 3'd2, 12'h014, 32'h0000_0104, rd, er, lat);
        chk("sw_lat", lat, 1);
        xact(0, 3'd2, 12'h014, 0, rd, er, lat);
        chk("lw_014", rd, 32'h0000_0104); chk("lw_014_err", 32'(er), 0); chk("lw_lat", lat, L);

        xact(1, 3'd2, 12'h020, 32'h1122_3344, rd, er, lat);
        xact(1, 3'd0, 12'h021, 32'h0000_00AA, rd, er, lat);
        xact(0, 3'd2, 12'h020, 0, rd, er, lat); chk("lw_020", rd, 32'h1122_AA44);
        xact(0, 3'd0, 12'h021, 0, rd, er, lat); chk("lb_021", rd, 32'hFFFF_FFAA);
        xact(0, 3'd4, 12'h021, 0, rd, er, lat); chk("lbu_021", rd, 32'h0000_00AA);

        xact(1, 3'd1, 12'h032, 32'h0000_8001, rd, er, lat);
        xact(0, 3'd1, 12'h032, 0, rd, er, lat); chk("lh_032", rd, 32'hFFFF_8001);
        xact(0, 3'd5, 12'h032, 0, rd, er, lat); chk("lhu_032", rd, 32'h0000_8001);
        xact(0, 3'd2, 12'h030, 0, rd, er, lat); chk("lw_030_hi", {16'd0, rd[31:16]}, 32'h8001);

        xact(1, 3'd2, 12'h040, 32'hDEAD_BEEF, rd, er, lat);
        xact(0, 3'd2, 12'h041, 0, rd, er, lat);
        chk("lw_mis_err", 32'(er), 1); chk("lw_mis_data", rd, 0); chk("err_lat", lat, 1);
        xact(1, 3'd1, 12'h043, 32'h1234, rd, er, lat);
        chk("sh_mis_err", 32'(er), 1); chk("sh_mis_data", rd, 0);
        xact(0, 3'd3, 12'h040, 0, rd, er, lat);
        chk("f3_011_err", 32'(er), 1); chk("f3_011_data", rd, 0);
        xact(1, 3'd4, 12'h040, 32'h55, rd, er, lat);
        chk("sbu_err", 32'(er), 1); chk("sbu_data", rd, 0);
        xact(0, 3'd2, 12'h040, 0, rd, er, lat); chk("lw_040_intact", rd, 32'hDEAD_BEEF);

        // Held response: a competing store request must be ignored.
        rsp_ready = 0;
        req_valid = 1; req_wr = 0; req_funct3 = 3'd2; req_addr = 12'h014;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready && n < 50);
        @(posedge clk); #1 req_wr = 1; req_wdata = 32'h0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 50);
        if (!rsp_valid) tmo("hold_valid");
        repeat (5) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 1); chk("hold_data", rsp_rdata, 32'h0000_0104);
            chk("hold_ready", 32'(req_ready), 0);
        end
        @(posedge clk); #1 req_valid = 0; rsp_ready = 1;
        @(posedge clk); #1;
        @(negedge clk); chk("post_hold_ready", 32'(req_ready), 1); chk("post_hold_valid", 32'(rsp_valid), 0);
        xact(0, 3'd2, 12'h014, 0, rd, er, lat); chk("lw_014_after_hold", rd, 32'h0000_0104);

        // Reset while a load sits in the latency wait.
        req_valid = 1; req_wr = 0; req_funct3 = 3'd2; req_addr = 12'h020;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready && n < 50);
        @(posedge clk); #1 req_valid = 0;
        @(negedge clk); chk("wait_valid", 32'(rsp_valid), 0);
        #2 rst = 0;
        @(posedge clk);
        @(posedge clk); #1 rst = 1;
        @(negedge clk); chk("rst_ready", 32'(req_ready), 1); chk("rst_valid", 32'(rsp_valid), 0);
        xact(0, 3'd2, 12'h020, 0, rd, er, lat); chk("lw_020_after_rst", rd, 32'h1122_AA44);

        bp_en = 1;
        repeat (300) begin
            wr = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) f3 = tbl[$urandom_range(0, 4)];
            a  = 12'($urandom_range(0, 255));
            if ($urandom_range(0, 1) != 0) a[1:0] = 2'b00;
            wd = $urandom;
            xact(wr, f3, a, wd, rd, er, lat);
            chk("lat_rand", lat, (legal_f(wr, f3, a) && !wr) ? L : 1);
        end
        bp_en = 0;
        @(posedge clk); #2 rsp_ready = 1;
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/ram_v2.md
Name: ram_v2

Overview:
- Parametrised, byte-addressable data RAM for the RISC-V core. Successor to the fixed 32x1024 word RAM.
- Adds RV32 load/store sizes (byte/half/word, signed/unsigned), byte-lane write enables, misalignment/illegal-size error reporting, configurable read latency and a valid/ready request/response handshake.
- Sits between the core's memory stage and on-chip storage; one outstanding transaction.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8. Only 32 is required to be supported.
- ADDR_W, 12, byte-address width; DEPTH = 2**(ADDR_W-2) words.
- READ_LAT, 1, cycles from request accept to read data valid; legal values 1..4.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request can be accepted
- req_wr  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 size code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, LSB-aligned
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_W  load data, aligned and extended; 0 for stores and errors
- rsp_err  out  1  misaligned access or illegal funct3

Behaviour:
- Handshakes
  - Request accepted on a rising edge with req_valid && req_ready.
  - Response completes on a rising edge with rsp_valid && rsp_ready.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On accept: go to WAIT if a legal load with READ_LAT>1; otherwise go to RESP.
  - WAIT: counter runs from 1 to READ_LAT-1, then go to RESP.
  - RESP: rsp_valid=1. Hold rsp_rdata and rsp_err stable until rsp_ready. On rsp_ready go to IDLE. No new accept in the same cycle.
  - req_ready=0 in WAIT and RESP.
- Word index is addr[ADDR_W-1:2]; lane is addr[1:0].
- Error conditions:
  - funct3 not in {000,001,010,100,101}.
  - H/HU with addr[0]=1.
  - W with addr[1:0]!=0.
  - Stores with funct3 100/101 are illegal.
  - On error: no array write, rsp_err=1, rsp_rdata=0, response after 1 cycle (RESP directly).
- Store
  - Write strobe per size: B = 1 lane; H = lanes {addr[1],0}; W = all 4 lanes.
  - Data is replicated/shifted into the selected lanes. Unselected bytes are unchanged.
  - Array write commits on the accept edge. rsp_valid asserts the next cycle with rsp_rdata=0, rsp_err=0.
- Load
  - Word read is registered. rsp_valid asserts READ_LAT cycles after the accept edge.
  - Selected byte/half is shifted to bit 0. B/H sign-extend from bit 7/15; BU/HU zero-extend.
  - A load accepted after a completed store to the same word returns the updated bytes.
- Reset (rst low, any time, including mid-transaction)
  - Outputs: req_ready=0 while rst low, 1 in the first cycle after release; rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - FSM goes to IDLE and the latency counter clears.
  - Array contents are not affected by reset. A store already committed stays committed. A pending load is dropped.
- Back-to-back: minimum transaction period is 2 cycles (accept, respond+consume) for READ_LAT=1.
- Address bits beyond DEPTH do not exist; no wrap logic is needed. The full ADDR_W byte space is the memory.

Decomposition:
- Shared package ram_pkg:
  - enum mem_size_e {SZ_B=3'b000, SZ_H=3'b001, SZ_W=3'b010, SZ_BU=3'b100, SZ_HU=3'b101}
  - enum ram_state_e {IDLE, WAIT, RESP}
  - function is_legal(size, wr, addr_lsbs)
- One sub-module: ram_v2_lane_align. Purely combinational. Store side produces the byte strobe and shifted write data. Load side produces the extracted, extended read data. Instantiated once in ram_v2.

Test Plan:
- Reset while in WAIT (READ_LAT=3) with a load pending -> rsp_valid stays 0. After release, req_ready=1. Prior memory contents are intact.
- SW 0x0000_0104 @0x014, then LW @0x014 -> rsp_rdata=0x0000_0104, rsp_err=0, rsp_valid exactly READ_LAT cycles after accept.
- SW 0x1122_3344 @0x020; SB 0xAA @0x021; LW @0x020 -> 0x1122_AA44. LB @0x021 -> 0xFFFF_FFAA. LBU @0x021 -> 0x0000_00AA.
- SH 0x8001 @0x032; LH @0x032 -> 0xFFFF_8001. LHU @0x032 -> 0x0000_8001. LW @0x030 shows the upper half = 0x8001.
- LW @0x041, SH @0x043, funct3=011 load, SBU(100) store -> each gives rsp_err=1, rsp_rdata=0. A following LW @0x040 shows the word is unchanged.
- Hold rsp_ready=0 for 5 cycles after a load -> rsp_valid and rsp_rdata stay stable, req_ready=0 and new req_valid is ignored. rsp_ready=1 -> IDLE next cycle.
